// File: rtl/pll_lock_rst_seq.sv
// Reset sequencer downstream of the PLL: qualifies lock, releases FABRIC_RSTN, requalifies on loss.
// Optional PLL_LOCK_SYNC_EN: 2-flop synchronizers on USR_PLL_LOCKED and USR_PLL_LOCKED_STDY.
module pll_lock_rst_seq #(
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned LOCK_CYCLES     = 16,
    parameter int unsigned STDY_RST_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES     = 8,
    parameter int unsigned LOSS_W          = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              USR_PLL_LOCKED,
    input  logic              USR_PLL_LOCKED_STDY,
    input  logic              USR_RSTN,
    output logic              USR_LOCKED_STDY_RST,
    output logic              FABRIC_RSTN,
    output logic              READY,
    output logic [LOSS_W-1:0] LOSS_CNT
);

    typedef enum logic [2:0] {
        StIdle,
        StClrStdy,
        StWaitLock,
        StRun,
        StLost
    } state_e;

    // Terminal counter values: a state lasting N cycles exits when the counter reads N-1.
    localparam logic [CNT_W-1:0]  StdyLast = CNT_W'(STDY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LockLast = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HoldLast = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LossMax  = '1;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             locked_s;
    logic             stdy_s;
    logic             lk;

`ifdef PLL_LOCK_SYNC_EN
    logic [1:0] locked_sync_q;
    logic [1:0] stdy_sync_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            locked_sync_q <= 2'b00;
            stdy_sync_q   <= 2'b00;
        end else begin
            locked_sync_q <= {locked_sync_q[0], USR_PLL_LOCKED};
            stdy_sync_q   <= {stdy_sync_q[0], USR_PLL_LOCKED_STDY};
        end
    end

    assign locked_s = locked_sync_q[1];
    assign stdy_s   = stdy_sync_q[1];
`else
    assign locked_s = USR_PLL_LOCKED;
    assign stdy_s   = USR_PLL_LOCKED_STDY;
`endif

    assign lk = locked_s & USR_RSTN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q             <= StIdle;
            cnt_q               <= '0;
            USR_LOCKED_STDY_RST <= 1'b0;
            FABRIC_RSTN         <= 1'b0;
            READY               <= 1'b0;
            LOSS_CNT            <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q             <= StClrStdy;
                    cnt_q               <= '0;
                    USR_LOCKED_STDY_RST <= 1'b1;
                    FABRIC_RSTN         <= 1'b0;
                    READY               <= 1'b0;
                end
                StClrStdy: begin
                    if (cnt_q == StdyLast) begin
                        state_q             <= StWaitLock;
                        cnt_q               <= '0;
                        USR_LOCKED_STDY_RST <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitLock: begin
                    if (!lk) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LockLast) begin
                        state_q     <= StRun;
                        cnt_q       <= '0;
                        FABRIC_RSTN <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (!stdy_s || !USR_RSTN) begin
                        state_q     <= StLost;
                        cnt_q       <= '0;
                        FABRIC_RSTN <= 1'b0;
                        READY       <= 1'b0;
                        // Only a real steady-lock drop is a loss; a user reset is not.
                        if (!stdy_s && (LOSS_CNT != LossMax)) begin
                            LOSS_CNT <= LOSS_CNT + 1'b1;
                        end
                    end else begin
                        READY <= stdy_s;
                    end
                end
                StLost: begin
                    if (cnt_q == HoldLast) begin
                        state_q             <= StClrStdy;
                        cnt_q               <= '0;
                        USR_LOCKED_STDY_RST <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q             <= StIdle;
                    cnt_q               <= '0;
                    USR_LOCKED_STDY_RST <= 1'b0;
                    FABRIC_RSTN         <= 1'b0;
                    READY               <= 1'b0;
                end
            endcase
        end
    end

endmodule
